// File: rtl/traffic_pkg.sv
// traffic_pkg: shared widths, game-state code, lane FSM encoding and level-to-period table
package traffic_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int PER_W = 17;
  localparam logic [1:0] GS_RUNNING = 2'b01;
  typedef enum logic [1:0] {IDLE, COUNT, STEP} lane_state_t;
  function automatic logic [PER_W-1:0] period_base(input logic [3:0] level);
    case (level)
      4'd2: return 17'd45000;
      4'd3: return 17'd40000;
      4'd4: return 17'd35000;
      4'd5: return 17'd30000;
      4'd6: return 17'd25000;
      4'd7: return 17'd20000;
      4'd8: return 17'd10000;
      default: return 17'd50000;
    endcase
  endfunction
endpackage

// File: rtl/speed_prescaler.sv
// speed_prescaler: level-dependent period counter; tick is high on the counting cycle that ends a period
//   i_Clk, i_Reset : clock, synchronous active-high reset
//   level          : game level selecting the base period
//   count_en       : high on each counting cycle (clears instead of incrementing when tick is high)
//   tick           : counter has reached the current period
// Optional TRAFFIC_JITTER_EN adds a 16-bit Galois LFSR that stretches each period pseudo-randomly.
module speed_prescaler
  import traffic_pkg::*;
#(
  parameter int SPEED_SHIFT = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] level,
  input  logic       count_en,
  output logic       tick
);
  logic [PER_W-1:0] cnt, period;
`ifdef TRAFFIC_JITTER_EN
  logic [15:0] lfsr;
  // The LFSR moves as the STEP state is entered; no compare happens during STEP, so this is
  // indistinguishable from advancing in the STEP cycle itself.
  always_ff @(posedge i_Clk)
    if (i_Reset) lfsr <= 16'hACE1;
    else if (count_en && tick) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign period = (period_base(level) >> SPEED_SHIFT) + (PER_W'({lfsr[2:0], 8'h00}) >> SPEED_SHIFT);
`else
  assign period = period_base(level) >> SPEED_SHIFT;
`endif
  // >= rather than == so a level change to a shorter period never lets the counter run free
  assign tick = cnt >= period;
  always_ff @(posedge i_Clk)
    if (i_Reset) cnt <= '0;
    else if (count_en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_lane_ctrl.sv
// traffic_lane_ctrl: moves NUM_CARS cars along one lane at a shared, level-dependent speed
//   i_Clk, i_Reset : clock, synchronous active-high reset
//   i_level        : game level 1..8
//   i_game_state   : 01 = running, anything else freezes the lane
//   o_carX         : packed car X positions, car k in bits [10k+9:10k]
//   o_carY         : lane Y (constant LANE_Y)
//   o_step         : high in the cycle positions are updated
//   o_running      : FSM is counting or stepping
// Build option TRAFFIC_JITTER_EN enables period jitter inside speed_prescaler.
module traffic_lane_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_CARS    = 3,
  parameter int LANE_Y      = 128,
  parameter int DIRECTION   = 1,
  parameter int GAME_WIDTH  = 640,
  parameter int X0          = 0,
  parameter int CAR_SPACING = 213,
  parameter int STEP_PX     = 1,
  parameter int SPEED_SHIFT = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [3:0]              i_level,
  input  logic [1:0]              i_game_state,
  output logic [X_W*NUM_CARS-1:0] o_carX,
  output logic [Y_W-1:0]          o_carY,
  output logic                    o_step,
  output logic                    o_running
);
  localparam logic [X_W:0] W = (X_W+1)'(GAME_WIDTH);
  localparam logic [X_W:0] S = (X_W+1)'(STEP_PX);
  lane_state_t state, state_nx;
  logic run, tick;
  assign run = i_game_state == GS_RUNNING;
  assign o_carY = Y_W'(LANE_Y);
  always_ff @(posedge i_Clk)
    state <= i_Reset ? IDLE : state_nx;
  // Pausing from COUNT keeps the prescaler value, so a resume finishes the interrupted period
  always_comb begin
    state_nx = state;
    o_step = 1'b0;
    o_running = 1'b0;
    case (state)
      IDLE: state_nx = run ? COUNT : IDLE;
      COUNT: begin
        state_nx = !run ? IDLE : tick ? STEP : COUNT;
        o_running = 1'b1;
      end
      STEP: begin
        state_nx = COUNT;
        o_step = 1'b1;
        o_running = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  speed_prescaler #(.SPEED_SHIFT(SPEED_SHIFT)) u_prescaler (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .level    (i_level),
    .count_en (state == COUNT && run),
    .tick     (tick)
  );
  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    localparam int START = (X0 + k * CAR_SPACING) % GAME_WIDTH;
    logic [X_W-1:0] x;
    logic [X_W:0] xe, up, nx;
    // One bit of headroom so x + STEP_PX and x + GAME_WIDTH never overflow before the wrap
    assign xe = {1'b0, x};
    assign up = xe + S;
    assign nx = DIRECTION != 0 ? (up >= W ? up - W : up) : (xe < S ? xe + W - S : xe - S);
    always_ff @(posedge i_Clk)
      if (i_Reset) x <= X_W'(START);
      else if (state == STEP) x <= X_W'(nx);
    assign o_carX[X_W*k +: X_W] = x;
  end
endmodule
